led_bank_arbiter: RTL

//   Shares the board's 8-LED bank between NUM_REQ on-chip status sources.

---
 rtl/led_bank_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/led_bank_arbiter.sv
// Round-robin owner arbitration of a shared LED bank with a minimum dwell per owner.
// Shows a heartbeat blink on led[0] whenever no source is requesting.
module led_bank_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LED_WIDTH    = 8,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned HB_BIT       = 23
) (
    input  logic                           clock_50,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*LED_WIDTH-1:0]   req_leds,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [LED_WIDTH-1:0]           led,
    output logic                           busy
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);
    localparam int unsigned HB_W    = 24;

    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t                 state, state_d;
    logic [NUM_REQ-1:0]     gnt_d;
    logic [LED_WIDTH-1:0]   led_d;
    logic                   busy_d;
    logic [DWELL_W-1:0]     dwell, dwell_d;
    logic [IDX_W-1:0]       last_owner, last_d;
    logic [HB_W-1:0]        hb;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [LED_WIDTH-1:0]   owner_leds;
    logic                   others_req;

    // Free-running heartbeat counter, wraps naturally at 2^24
    always_ff @(posedge clock_50) begin
        if (reset) begin
            hb <= '0;
        end else begin
            hb <= hb + HB_W'(1);
        end
    end

    // Round-robin scan starting just after last_owner; last_owner itself is checked last
    always_comb begin
        int unsigned cand;
        pick_valid = 1'b0;
        pick_idx   = last_owner;
        cand       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(last_owner) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_valid && req[IDX_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Pattern of the current owner
    always_comb begin
        owner_leds = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (last_owner == IDX_W'(i)) begin
                owner_leds = req_leds[i*LED_WIDTH +: LED_WIDTH];
            end
        end
    end

    assign others_req = |(req & ~gnt);

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        led_d   = led;
        dwell_d = dwell;
        last_d  = last_owner;

        unique case (state)
            IDLE: begin
                led_d   = LED_WIDTH'(hb[HB_BIT]);
                gnt_d   = '0;
                dwell_d = '0;
                if (pick_valid) begin
                    state_d = OWN;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    last_d  = pick_idx;
                end
            end
            OWN: begin
                led_d = owner_leds;
                if (!req[last_owner] || (dwell == DWELL_MAX && others_req)) begin
                    state_d = SWITCH;
                    gnt_d   = '0;
                end else if (dwell != DWELL_MAX) begin
                    dwell_d = dwell + DWELL_W'(1);
                end
            end
            SWITCH: begin
                gnt_d   = '0;
                dwell_d = '0;
                if (pick_valid) begin
                    state_d = OWN;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    last_d  = pick_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                dwell_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            led        <= '0;
            busy       <= 1'b0;
            dwell      <= '0;
            last_owner <= LAST_RST;
        end else begin
            state      <= state_d;
            gnt        <= gnt_d;
            led        <= led_d;
            busy       <= busy_d;
            dwell      <= dwell_d;
            last_owner <= last_d;
        end
    end

endmodule
